aclk_time_counter: RTL and testbench
====================================

# aclk_time_counter

Parametrised successor to the alarm-clock current-time counter. It holds time of day as BCD digits: hours 00–23, minutes and, optionally, seconds. It advances on a single-cycle tick and accepts a synchronous parallel load, which is validated before it takes effect. It presents the time in either 24 h or 12 h form with an AM/PM flag, and pulses a day-rollover strobe for the alarm/calendar logic downstream.

## Interface
Parameters:
- SECONDS_EN, default 1: 1 = seconds digits present, `tick` is a one-second strobe; 0 = no seconds field, `tick` is a one-minute strobe, seconds outputs tied 0, seconds load inputs ignored.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle advance strobe (second or minute per SECONDS_EN).
- load_new_c  in  1  load request; new_* digits sampled on the same edge.
- mode_12h  in  1  0 = 24 h presentation, 1 = 12 h presentation.
- new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec  in  4 each  load digits, always 24 h BCD.
- current_time_ms_hr, current_time_ls_hr  out  4 each  hour digits, in presentation format.
- current_time_ms_min, current_time_ls_min, current_time_ms_sec, current_time_ls_sec  out  4 each  registered BCD digits.
- pm  out  1  1 when the internal hour is 12–23, independent of mode_12h.
- day_tick  out  1  registered one-cycle pulse on rollover to 00:00(:00).
- load_err  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- Internal state: six 4-bit BCD registers, always kept in 24 h form.
- Priority per edge: reset > load_new_c > tick.
- Reset: all digits 0; day_tick = 0; load_err = 0.
- Load validity: ms_hr ≤ 2; ls_hr ≤ 9, and ls_hr ≤ 3 when ms_hr = 2; ms_min ≤ 5; ls_min ≤ 9; ms_sec ≤ 5; ls_sec ≤ 9. Seconds checks apply only when SECONDS_EN = 1.
- Valid load: all digits are replaced; when SECONDS_EN = 0, seconds stay 0.
- Invalid load: no digit changes; load_err = 1 for exactly the next cycle.
- A tick in the same cycle as any load (valid or not) is discarded and not deferred.
- Tick increment is ripple BCD:
  - ls_sec 9→0 carries into ms_sec; ms_sec 5→0 carries into minutes.
  - ls_min 9→0 carries into ms_min; ms_min 5→0 carries into hours.
  - Hours step 09→10, 19→20, 23→00.
- Rollover 23:59:59 (or 23:59 when SECONDS_EN = 0) → all digits 0, and day_tick = 1 for one cycle.
- A load to 00:00:00 does not assert day_tick.
- Presentation is combinational decode from the registered hour and mode_12h:
  - mode_12h = 0: hour digits passed through unchanged.
  - mode_12h = 1: hour 00 → 12; 01–11 unchanged; 12 → 12; 13–23 → hour − 12 in BCD (e.g. 13→01, 20→08, 23→11).
- Changing mode_12h affects only the hour outputs, in the same cycle; stored state is untouched.

## Timing
- Load and tick take effect at the capturing rising edge; outputs show the new value one clock later. Latency is 1 cycle.
- day_tick and load_err are asserted in the cycle after the causing edge, for one cycle only.
- A tick held high for N cycles advances the time N steps; no edge detection is performed.
- Reset asserted mid-operation clears state on the next edge regardless of tick or load_new_c. Any pending day_tick or load_err is cleared.
- Outputs while reset is active: 24 h mode shows 0 0:0 0:0 0; 12 h mode shows 1 2:0 0:0 0 with pm = 0.
- No undefined states: registers hold only values reachable by valid load or increment.

## Test plan
- Reset, then a single tick (SECONDS_EN = 1) → 00:00:01, day_tick = 0, load_err = 0.
- Load 23:59:59, then one tick → 00:00:00, day_tick high exactly one cycle, pm goes 1→0.
- Load 13:05:00 with mode_12h = 1 → hour outputs 0 1, pm = 1. Toggle to mode_12h = 0 → 1 3 in the same cycle. Load 00:30:00 in 12 h mode → 1 2, pm = 0.
- Load 24:00:00, then 19:60:00, from a held time of 10:10:10 → load_err pulses once per attempt; time stays 10:10:10.
- load_new_c and tick in the same cycle, loading 08:00:00 → result 08:00:00, not 08:00:01. Reset asserted together with load_new_c → 00:00:00.
- SECONDS_EN = 0 instance: load 23:59, apply 256 one-cycle ticks separated by idle cycles → final 04:15, day_tick pulsed exactly once, seconds outputs 0 throughout.

Source files
------------

// File: rtl/aclk_time_counter_if.sv
// Control/data bundle for the time-of-day counter: load digits and tick in, presented time and status out.
interface aclk_time_counter_if;
    logic       tick;
    logic       load_new_c;
    logic       mode_12h;
    logic [3:0] new_ms_hr;
    logic [3:0] new_ls_hr;
    logic [3:0] new_ms_min;
    logic [3:0] new_ls_min;
    logic [3:0] new_ms_sec;
    logic [3:0] new_ls_sec;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic [3:0] current_time_ms_sec;
    logic [3:0] current_time_ls_sec;
    logic       pm;
    logic       day_tick;
    logic       load_err;

    modport master (
        output tick, load_new_c, mode_12h,
        output new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec,
        input  current_time_ms_hr, current_time_ls_hr, current_time_ms_min,
        input  current_time_ls_min, current_time_ms_sec, current_time_ls_sec,
        input  pm, day_tick, load_err
    );

    modport slave (
        input  tick, load_new_c, mode_12h,
        input  new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_ms_sec, new_ls_sec,
        output current_time_ms_hr, current_time_ls_hr, current_time_ms_min,
        output current_time_ls_min, current_time_ms_sec, current_time_ls_sec,
        output pm, day_tick, load_err
    );
endinterface

// File: rtl/aclk_time_counter.sv
// BCD time-of-day counter (24 h internal state) with validated load, 12/24 h hour decode,
// day-rollover strobe and load-reject strobe.
module aclk_time_counter #(
    parameter bit SECONDS_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    aclk_time_counter_if.slave    bus
);

    logic [3:0] ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec;
    logic       day_tick_r, load_err_r;

    logic [3:0] nx_ms_hr, nx_ls_hr, nx_ms_min, nx_ls_min, nx_ms_sec, nx_ls_sec;
    logic [4:0] s_ls_sec, s_ms_sec, s_ls_min, s_ms_min;
    logic       min_cy, hr_cy, wrap;
    logic       load_ok;
    logic [3:0] hr_ms_out, hr_ls_out;

    // {carry, next digit}; ">=" keeps the wrap safe even for a digit above its top value
    function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic [3:0] top);
        if (d >= top)
            bcd_step = 5'b1_0000;
        else
            bcd_step = {1'b0, d + 4'd1};
    endfunction

    function automatic logic load_valid(
        input logic [3:0] mh, input logic [3:0] lh, input logic [3:0] mm,
        input logic [3:0] lm, input logic [3:0] msec, input logic [3:0] lsec
    );
        logic hr_ok, min_ok, sec_ok;
        hr_ok  = (mh <= 4'd2) && (lh <= 4'd9) && !((mh == 4'd2) && (lh > 4'd3));
        min_ok = (mm <= 4'd5) && (lm <= 4'd9);
        sec_ok = !SECONDS_EN || ((msec <= 4'd5) && (lsec <= 4'd9));
        load_valid = hr_ok && min_ok && sec_ok;
    endfunction

    assign load_ok = load_valid(bus.new_ms_hr, bus.new_ls_hr, bus.new_ms_min,
                                bus.new_ls_min, bus.new_ms_sec, bus.new_ls_sec);

    assign s_ls_sec = bcd_step(ls_sec, 4'd9);
    assign s_ms_sec = bcd_step(ms_sec, 4'd5);
    assign s_ls_min = bcd_step(ls_min, 4'd9);
    assign s_ms_min = bcd_step(ms_min, 4'd5);

    always_comb begin
        nx_ms_hr  = ms_hr;
        nx_ls_hr  = ls_hr;
        nx_ms_min = ms_min;
        nx_ls_min = ls_min;
        nx_ms_sec = ms_sec;
        nx_ls_sec = ls_sec;
        wrap      = 1'b0;
        min_cy    = SECONDS_EN ? (s_ls_sec[4] & s_ms_sec[4]) : 1'b1;
        hr_cy     = min_cy & s_ls_min[4] & s_ms_min[4];
        if (SECONDS_EN) begin
            nx_ls_sec = s_ls_sec[3:0];
            if (s_ls_sec[4])
                nx_ms_sec = s_ms_sec[3:0];
        end
        if (min_cy) begin
            nx_ls_min = s_ls_min[3:0];
            if (s_ls_min[4])
                nx_ms_min = s_ms_min[3:0];
        end
        if (hr_cy) begin
            if ((ms_hr == 4'd2) && (ls_hr >= 4'd3)) begin
                nx_ms_hr = 4'd0;
                nx_ls_hr = 4'd0;
                wrap     = 1'b1;
            end else if (ls_hr >= 4'd9) begin
                nx_ms_hr = ms_hr + 4'd1;
                nx_ls_hr = 4'd0;
            end else begin
                nx_ls_hr = ls_hr + 4'd1;
            end
        end
    end

    // Load beats tick; a tick arriving with any load is simply dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_hr      <= 4'd0;
            ls_hr      <= 4'd0;
            ms_min     <= 4'd0;
            ls_min     <= 4'd0;
            ms_sec     <= 4'd0;
            ls_sec     <= 4'd0;
            day_tick_r <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            day_tick_r <= 1'b0;
            load_err_r <= 1'b0;
            if (bus.load_new_c) begin
                if (load_ok) begin
                    ms_hr  <= bus.new_ms_hr;
                    ls_hr  <= bus.new_ls_hr;
                    ms_min <= bus.new_ms_min;
                    ls_min <= bus.new_ls_min;
                    ms_sec <= SECONDS_EN ? bus.new_ms_sec : 4'd0;
                    ls_sec <= SECONDS_EN ? bus.new_ls_sec : 4'd0;
                end else begin
                    load_err_r <= 1'b1;
                end
            end else if (bus.tick) begin
                ms_hr      <= nx_ms_hr;
                ls_hr      <= nx_ls_hr;
                ms_min     <= nx_ms_min;
                ls_min     <= nx_ls_min;
                ms_sec     <= nx_ms_sec;
                ls_sec     <= nx_ls_sec;
                day_tick_r <= wrap;
            end
        end
    end

    // 12 h decode: 00 -> 12, 13..19 -> 01..07, 20..21 -> 08..09, 22..23 -> 10..11
    always_comb begin
        hr_ms_out = ms_hr;
        hr_ls_out = ls_hr;
        if (bus.mode_12h) begin
            if ((ms_hr == 4'd0) && (ls_hr == 4'd0)) begin
                hr_ms_out = 4'd1;
                hr_ls_out = 4'd2;
            end else if ((ms_hr == 4'd1) && (ls_hr >= 4'd3)) begin
                hr_ms_out = 4'd0;
                hr_ls_out = ls_hr - 4'd2;
            end else if ((ms_hr == 4'd2) && (ls_hr <= 4'd1)) begin
                hr_ms_out = 4'd0;
                hr_ls_out = ls_hr + 4'd8;
            end else if (ms_hr == 4'd2) begin
                hr_ms_out = 4'd1;
                hr_ls_out = ls_hr - 4'd2;
            end
        end
    end

    assign bus.current_time_ms_hr  = hr_ms_out;
    assign bus.current_time_ls_hr  = hr_ls_out;
    assign bus.current_time_ms_min = ms_min;
    assign bus.current_time_ls_min = ls_min;
    assign bus.current_time_ms_sec = SECONDS_EN ? ms_sec : 4'd0;
    assign bus.current_time_ls_sec = SECONDS_EN ? ls_sec : 4'd0;
    assign bus.pm       = (ms_hr == 4'd2) || ((ms_hr == 4'd1) && (ls_hr >= 4'd2));
    assign bus.day_tick = day_tick_r;
    assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Directed bench for aclk_time_counter: a seconds-enabled instance and a minutes-only instance.
module tb_aclk_time_counter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   day_count;
    int   sec_bad;

    aclk_time_counter_if ifa ();
    aclk_time_counter_if ifb ();

    aclk_time_counter #(.SECONDS_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    aclk_time_counter #(.SECONDS_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] tm_a();
        return {ifa.current_time_ms_hr, ifa.current_time_ls_hr, ifa.current_time_ms_min,
                ifa.current_time_ls_min, ifa.current_time_ms_sec, ifa.current_time_ls_sec};
    endfunction

    function automatic logic [23:0] tm_b();
        return {ifb.current_time_ms_hr, ifb.current_time_ls_hr, ifb.current_time_ms_min,
                ifb.current_time_ls_min, ifb.current_time_ms_sec, ifb.current_time_ls_sec};
    endfunction

    task automatic set_a(input logic [23:0] t);
        {ifa.new_ms_hr, ifa.new_ls_hr, ifa.new_ms_min,
         ifa.new_ls_min, ifa.new_ms_sec, ifa.new_ls_sec} = t;
    endtask

    task automatic set_b(input logic [23:0] t);
        {ifb.new_ms_hr, ifb.new_ls_hr, ifb.new_ms_min,
         ifb.new_ls_min, ifb.new_ms_sec, ifb.new_ls_sec} = t;
    endtask

    task automatic load_a(input logic [23:0] t);
        set_a(t);
        ifa.load_new_c = 1'b1;
        cyc();
        ifa.load_new_c = 1'b0;
    endtask

    task automatic tick_a();
        ifa.tick = 1'b1;
        cyc();
        ifa.tick = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        day_count = 0;
        sec_bad = 0;
        reset = 1'b1;
        ifa.tick = 1'b0; ifa.load_new_c = 1'b0; ifa.mode_12h = 1'b0; set_a(24'h0);
        ifb.tick = 1'b0; ifb.load_new_c = 1'b0; ifb.mode_12h = 1'b0; set_b(24'h0);

        // reset state, both presentations
        cyc();
        check("reset_time", tm_a(), 24'h000000);
        check("reset_day_tick", {23'd0, ifa.day_tick}, 24'd0);
        check("reset_load_err", {23'd0, ifa.load_err}, 24'd0);
        ifa.mode_12h = 1'b1;
        #1;
        check("reset_12h_time", tm_a(), 24'h120000);
        check("reset_12h_pm", {23'd0, ifa.pm}, 24'd0);
        ifa.mode_12h = 1'b0;

        // first tick
        reset = 1'b0;
        tick_a();
        check("first_tick", tm_a(), 24'h000001);
        check("first_tick_day", {23'd0, ifa.day_tick}, 24'd0);
        check("first_tick_err", {23'd0, ifa.load_err}, 24'd0);

        // day rollover
        load_a(24'h235959);
        check("load_235959", tm_a(), 24'h235959);
        check("pm_before_roll", {23'd0, ifa.pm}, 24'd1);
        tick_a();
        check("rollover_time", tm_a(), 24'h000000);
        check("rollover_day_tick", {23'd0, ifa.day_tick}, 24'd1);
        check("pm_after_roll", {23'd0, ifa.pm}, 24'd0);
        cyc();
        check("day_tick_one_cycle", {23'd0, ifa.day_tick}, 24'd0);

        // load to midnight never strobes day_tick
        load_a(24'h000000);
        check("load_midnight_day", {23'd0, ifa.day_tick}, 24'd0);

        // hour carries
        load_a(24'h095959);
        tick_a();
        check("carry_09_10", tm_a(), 24'h100000);
        load_a(24'h195959);
        tick_a();
        check("carry_19_20", tm_a(), 24'h200000);
        load_a(24'h124959);
        tick_a();
        check("carry_min", tm_a(), 24'h125000);

        // tick held high for three cycles
        load_a(24'h100000);
        ifa.tick = 1'b1;
        cyc(); cyc(); cyc();
        ifa.tick = 1'b0;
        check("held_tick_3", tm_a(), 24'h100003);

        // 12 h presentation
        ifa.mode_12h = 1'b1;
        load_a(24'h130500);
        check("12h_13", tm_a(), 24'h010500);
        check("12h_13_pm", {23'd0, ifa.pm}, 24'd1);
        ifa.mode_12h = 1'b0;
        #1;
        check("24h_13_same_cycle", tm_a(), 24'h130500);
        ifa.mode_12h = 1'b1;
        load_a(24'h003000);
        check("12h_00", tm_a(), 24'h123000);
        check("12h_00_pm", {23'd0, ifa.pm}, 24'd0);
        load_a(24'h120000);
        check("12h_12", tm_a(), 24'h120000);
        check("12h_12_pm", {23'd0, ifa.pm}, 24'd1);
        load_a(24'h200000);
        check("12h_20", tm_a(), 24'h080000);
        load_a(24'h234500);
        check("12h_23", tm_a(), 24'h114500);
        load_a(24'h110000);
        check("12h_11", tm_a(), 24'h110000);
        check("12h_11_pm", {23'd0, ifa.pm}, 24'd0);
        ifa.mode_12h = 1'b0;

        // rejected loads leave 10:10:10 in place
        load_a(24'h101010);
        check("valid_load_no_err", {23'd0, ifa.load_err}, 24'd0);
        load_a(24'h240000);
        check("bad_hr_err", {23'd0, ifa.load_err}, 24'd1);
        check("bad_hr_time", tm_a(), 24'h101010);
        cyc();
        check("bad_hr_err_clear", {23'd0, ifa.load_err}, 24'd0);
        load_a(24'h196000);
        check("bad_min_err", {23'd0, ifa.load_err}, 24'd1);
        check("bad_min_time", tm_a(), 24'h101010);
        cyc();
        check("bad_min_err_clear", {23'd0, ifa.load_err}, 24'd0);
        load_a(24'h101060);
        check("bad_sec_err", {23'd0, ifa.load_err}, 24'd1);
        check("bad_sec_time", tm_a(), 24'h101010);
        load_a(24'h0A0000);
        check("bad_ls_hr_err", {23'd0, ifa.load_err}, 24'd1);

        // load wins over a simultaneous tick; reset wins over load
        ifa.tick = 1'b1;
        load_a(24'h080000);
        ifa.tick = 1'b0;
        check("load_beats_tick", tm_a(), 24'h080000);
        reset = 1'b1;
        load_a(24'h123456);
        check("reset_beats_load", tm_a(), 24'h000000);
        load_a(24'h240000);
        check("reset_clears_err", {23'd0, ifa.load_err}, 24'd0);
        reset = 1'b0;

        // minutes-only instance: seconds digits ignored on load
        set_b(24'h120079);
        ifb.load_new_c = 1'b1;
        cyc();
        ifb.load_new_c = 1'b0;
        check("b_sec_ignored_err", {23'd0, ifb.load_err}, 24'd0);
        check("b_sec_ignored_time", tm_b(), 24'h120000);

        set_b(24'h235959);
        ifb.load_new_c = 1'b1;
        cyc();
        ifb.load_new_c = 1'b0;
        check("b_load_2359", tm_b(), 24'h235900);
        for (int i = 0; i < 256; i++) begin
            ifb.tick = 1'b1;
            cyc();
            ifb.tick = 1'b0;
            day_count += int'(ifb.day_tick);
            if ({ifb.current_time_ms_sec, ifb.current_time_ls_sec} != 8'h00) sec_bad++;
            cyc();
            day_count += int'(ifb.day_tick);
            if ({ifb.current_time_ms_sec, ifb.current_time_ls_sec} != 8'h00) sec_bad++;
        end
        check("b_final_time", tm_b(), 24'h041500);
        check("b_day_tick_count", day_count[23:0], 24'd1);
        check("b_seconds_zero", sec_bad[23:0], 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
